mem_bus_ctrl: RTL and testbench

//  Memory-bus sequencer between the PUNEH datapath and word-wide external memory.
//  - Takes one-cycle read/write requests from the controller and drives a req/ready handshake to memory.
//  - Captures read data for the IR/register inputs, supports wait states and bounds each access with a timeout.

---
 rtl/puneh_pkg.sv | 12 +
 rtl/mem_bus_ctrl_access_timer.sv | 36 +++
 rtl/mem_bus_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/puneh_pkg.sv
// Shared types and default widths for the PUNEH memory-bus slice.
package puneh_pkg;

  localparam int DW = 16;
  localparam int AW = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_bus_ctrl_access_timer.sv
// Wait-state counter that bounds one memory access and flags when the limit is reached.
module access_timer #(
  parameter int TW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Clear wins so a fresh access always starts counting from zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == TW'(TIMEOUT));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus sequencer: turns one-cycle read/write requests into a strobe/ready
// handshake with wait states, a timeout abort and a flush.
module mem_bus_ctrl
  import puneh_pkg::*;
#(
  parameter int DW      = puneh_pkg::DW,
  parameter int AW      = puneh_pkg::AW,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_rd,
  input  logic          start_wr,
  input  logic          flush,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  mem_state_t    state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          start_accept;
  logic          timer_en;
  logic          timer_expired;

  assign start_accept = (state_q == IDLE) && (start_rd || start_wr);
  assign timer_en     = (state_q == ACCESS) && !mem_ready;

  access_timer #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_access_timer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (start_accept),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  // Within ACCESS the exit priority is flush, then mem_ready, then timeout.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (start_accept) begin
          state_d     = ACCESS;
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
          mem_rd_d    = start_rd;
          mem_wr_d    = start_wr && !start_rd;
          err_d       = 1'b0;
        end
      end
      ACCESS: begin
        if (flush) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
        end else if (mem_ready) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b0;
          if (mem_rd_q) begin
            rdata_d = mem_rdata;
          end
        end else if (timer_expired) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl with hand-computed expectations.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        startRd;
  logic        startWr;
  logic        flush;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        memRd;
  logic        memWr;
  logic [15:0] memRdata;
  logic        memReady;

  int evalCount;
  int failCount;

  mem_bus_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_rd  (startRd),
    .start_wr  (startWr),
    .flush     (flush),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_rd    (memRd),
    .mem_wr    (memWr),
    .mem_rdata (memRdata),
    .mem_ready (memReady)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives every request/memory-side input at once.
  task automatic applyStimulus(input logic rd, input logic wr, input logic rdy,
                               input logic [15:0] memData, input logic [15:0] a,
                               input logic [15:0] wd, input logic fl);
    startRd  = rd;
    startWr  = wr;
    memReady = rdy;
    memRdata = memData;
    addr     = a;
    wdata    = wd;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    evalCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    evalCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Linear directed sequence; each check sits 1 ns after a rising edge.
  initial begin
    evalCount = 0;
    failCount = 0;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    #12;
    checkFlag("reset_busy", busy, 1'b0);
    checkFlag("reset_done", done, 1'b0);
    checkFlag("reset_err", err, 1'b0);
    checkFlag("reset_mem_rd", memRd, 1'b0);
    checkFlag("reset_mem_wr", memWr, 1'b0);
    checkOutput("reset_rdata", rdata, 16'h0000);
    checkOutput("reset_mem_addr", memAddr, 16'h0000);
    checkOutput("reset_mem_wdata", memWdata, 16'h0000);
    rst = 1'b1;
    tick();

    $display("[TB] zero-wait read");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0040, 16'h0000, 1'b0);
    tick();
    checkFlag("rd0_mem_rd", memRd, 1'b1);
    checkFlag("rd0_mem_wr", memWr, 1'b0);
    checkFlag("rd0_busy", busy, 1'b1);
    checkOutput("rd0_mem_addr", memAddr, 16'h0040);
    checkFlag("rd0_no_early_done", done, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0000, 16'h0000, 1'b0);
    tick();
    checkFlag("rd0_done", done, 1'b1);
    checkFlag("rd0_err", err, 1'b0);
    checkOutput("rd0_rdata", rdata, 16'hBEEF);
    checkFlag("rd0_strobe_drop", memRd, 1'b0);
    checkFlag("rd0_idle", busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tick();
    checkFlag("rd0_done_pulse", done, 1'b0);
    checkOutput("rd0_rdata_hold", rdata, 16'hBEEF);

    $display("[TB] write with three wait states");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h1234, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h5555, 16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkFlag("wr_mem_wr_wait", memWr, 1'b1);
      checkOutput("wr_mem_wdata_stable", memWdata, 16'h1234);
      checkOutput("wr_mem_addr_stable", memAddr, 16'h0100);
      checkFlag("wr_no_done_wait", done, 1'b0);
      tick();
    end
    checkFlag("wr_mem_wr_last", memWr, 1'b1);
    checkFlag("wr_mem_rd_never", memRd, 1'b0);
    memReady = 1'b1;
    tick();
    checkFlag("wr_done", done, 1'b1);
    checkFlag("wr_err", err, 1'b0);
    checkFlag("wr_strobe_drop", memWr, 1'b0);
    checkOutput("wr_rdata_untouched", rdata, 16'hBEEF);

    $display("[TB] read timeout");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0200, 16'h0000, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'hDEAD, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkFlag("to_mem_rd_held", memRd, 1'b1);
      checkFlag("to_no_early_done", done, 1'b0);
      tick();
    end
    checkFlag("to_done", done, 1'b1);
    checkFlag("to_err", err, 1'b1);
    checkFlag("to_strobe_drop", memRd, 1'b0);
    checkOutput("to_rdata_kept", rdata, 16'hBEEF);
    tick();
    checkFlag("to_done_pulse", done, 1'b0);
    checkFlag("to_err_hold", err, 1'b1);

    $display("[TB] simultaneous read and write request");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0300, 16'h9999, 1'b0);
    tick();
    checkFlag("both_mem_rd", memRd, 1'b1);
    checkFlag("both_mem_wr", memWr, 1'b0);
    checkFlag("both_err_cleared", err, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0A0A, 16'h0000, 16'h0000, 1'b0);
    tick();
    checkFlag("both_done", done, 1'b1);
    checkOutput("both_rdata", rdata, 16'h0A0A);
    checkFlag("both_no_write", memWr, 1'b0);

    $display("[TB] back-to-back read in the done cycle");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0400, 16'h0000, 1'b0);
    tick();
    checkFlag("b2b_mem_rd", memRd, 1'b1);
    checkOutput("b2b_mem_addr", memAddr, 16'h0400);
    checkFlag("b2b_busy", busy, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0500, 16'h7777, 1'b0);
    tick();
    checkFlag("b2b_ignore_rd", memRd, 1'b1);
    checkFlag("b2b_ignore_wr", memWr, 1'b0);
    checkOutput("b2b_ignore_addr", memAddr, 16'h0400);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1111, 16'h0000, 16'h0000, 1'b0);
    tick();
    checkFlag("b2b_done", done, 1'b1);
    checkOutput("b2b_rdata", rdata, 16'h1111);

    $display("[TB] flush against mem_ready, then async reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0600, 16'h0000, 1'b0);
    tick();
    checkFlag("fl_mem_rd", memRd, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h2222, 16'h0000, 16'h0000, 1'b1);
    tick();
    checkFlag("fl_idle", busy, 1'b0);
    checkFlag("fl_no_done", done, 1'b0);
    checkFlag("fl_strobe_drop", memRd, 1'b0);
    checkOutput("fl_rdata_kept", rdata, 16'h1111);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0700, 16'h0000, 1'b0);
    tick();
    checkFlag("rst_pre_mem_rd", memRd, 1'b1);
    startRd = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkFlag("rst_mem_rd", memRd, 1'b0);
    checkFlag("rst_busy", busy, 1'b0);
    checkFlag("rst_done", done, 1'b0);
    checkOutput("rst_rdata", rdata, 16'h0000);
    checkOutput("rst_mem_addr", memAddr, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
    $finish;
  end

endmodule
